// File: rtl/rs_parity_line_buffer_if.sv
// Write/clear and valid/ready read bus of the banked parity line buffer.
// The master modport is the producer/consumer side; the slave modport is the buffer itself.
interface rs_parity_line_buffer_if #(
    parameter int unsigned DATA_W       = 512,
    parameter int unsigned PARITY_W     = 128,
    parameter int unsigned DEPTH_BLOCKS = 64
) ();
    localparam int unsigned NUM_BANKS = DATA_W / PARITY_W;
    localparam int unsigned LINE_W    = $clog2(DEPTH_BLOCKS / NUM_BANKS);
    localparam int unsigned BLK_W     = $clog2(DEPTH_BLOCKS);

    logic                clear;
    logic                wr_val;
    logic [BLK_W-1:0]    wr_addr;
    logic [PARITY_W-1:0] wr_data;
    logic                rd_req_val;
    logic [LINE_W-1:0]   rd_req_addr;
    logic                rd_req_rdy;
    logic                rd_resp_val;
    logic [DATA_W-1:0]   rd_resp_data;
    logic                rd_resp_rdy;

    modport master (
        output clear, wr_val, wr_addr, wr_data, rd_req_val, rd_req_addr, rd_resp_rdy,
        input  rd_req_rdy, rd_resp_val, rd_resp_data
    );

    modport slave (
        input  clear, wr_val, wr_addr, wr_data, rd_req_val, rd_req_addr, rd_resp_rdy,
        output rd_req_rdy, rd_resp_val, rd_resp_data
    );
endinterface

// File: rtl/rs_parity_line_buffer.sv
// Banked parity store: one parity word written per block, read back NUM_BANKS blocks
// per line (lowest block in the MS lane) through a 2-entry response buffer.
module rs_parity_line_buffer #(
    parameter int unsigned DATA_W       = 512,
    parameter int unsigned PARITY_W     = 128,
    parameter int unsigned DEPTH_BLOCKS = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    rs_parity_line_buffer_if.slave bus
);
    localparam int unsigned NUM_BANKS = DATA_W / PARITY_W;
    localparam int unsigned ROWS      = DEPTH_BLOCKS / NUM_BANKS;
    localparam int unsigned LINE_W    = $clog2(ROWS);
    localparam int unsigned BLK_W     = $clog2(DEPTH_BLOCKS);
    localparam int unsigned BANK_W    = $clog2(NUM_BANKS);

    logic [PARITY_W-1:0]     mem [NUM_BANKS][ROWS];
    logic [DEPTH_BLOCKS-1:0] vld;
    logic [DEPTH_BLOCKS-1:0] vld_n;
    logic [BANK_W-1:0]       wr_bank;
    logic [LINE_W-1:0]       wr_row;

    logic [DATA_W-1:0]       line_c;
    logic                    acc;
    logic                    pop;

    logic                    rdy_q;
    logic                    rdy_n;
    logic                    head_val;
    logic                    head_val_n;
    logic [DATA_W-1:0]       head_q;
    logic [DATA_W-1:0]       head_n;
    logic                    skid_val;
    logic                    skid_val_n;
    logic [DATA_W-1:0]       skid_q;
    logic [DATA_W-1:0]       skid_n;
    logic [1:0]              occ_n;

    assign wr_bank = bus.wr_addr[BANK_W-1:0];
    assign wr_row  = bus.wr_addr[BLK_W-1:BANK_W];

    // Data arrays carry no reset; the valid bits decide what is visible.
    always_ff @(posedge clk) begin
        if (bus.wr_val) begin
            mem[wr_bank][wr_row] <= bus.wr_data;
        end
    end

    // A write in the same cycle as clear survives the clear.
    always_comb begin
        vld_n = bus.clear ? '0 : vld;
        if (bus.wr_val) begin
            vld_n[bus.wr_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld <= vld_n;
        end
    end

    // Combinational line read against current registers gives read-first behaviour.
    always_comb begin
        line_c = '0;
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            if (vld[{bus.rd_req_addr, BANK_W'(b)}]) begin
                line_c[DATA_W-1-b*PARITY_W -: PARITY_W] = mem[BANK_W'(b)][bus.rd_req_addr];
            end
        end
    end

    assign acc = bus.rd_req_val & rdy_q;
    assign pop = head_val & bus.rd_resp_rdy;

    // Head register drives the response directly; skid holds the second entry.
    always_comb begin
        head_val_n = head_val;
        head_n     = head_q;
        skid_val_n = skid_val;
        skid_n     = skid_q;
        if (pop) begin
            if (skid_val) begin
                head_n     = skid_q;
                skid_val_n = acc;
                if (acc) begin
                    skid_n = line_c;
                end
            end else begin
                head_val_n = acc;
                if (acc) begin
                    head_n = line_c;
                end
            end
        end else if (acc) begin
            if (!head_val) begin
                head_val_n = 1'b1;
                head_n     = line_c;
            end else begin
                skid_val_n = 1'b1;
                skid_n     = line_c;
            end
        end
        occ_n = {1'b0, head_val_n} + {1'b0, skid_val_n};
        rdy_n = (occ_n < 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_val <= 1'b0;
            head_q   <= '0;
            skid_val <= 1'b0;
            skid_q   <= '0;
            rdy_q    <= 1'b0;
        end else begin
            head_val <= head_val_n;
            head_q   <= head_n;
            skid_val <= skid_val_n;
            skid_q   <= skid_n;
            rdy_q    <= rdy_n;
        end
    end

    assign bus.rd_req_rdy   = rdy_q;
    assign bus.rd_resp_val  = head_val;
    assign bus.rd_resp_data = head_q;

endmodule

// File: tb/tb_rs_parity_line_buffer.sv
// Directed bench for rs_parity_line_buffer: table-driven line reads plus
// hand-written backpressure, read-first and mid-stream reset sequences.
module tb_rs_parity_line_buffer;
    localparam int unsigned DATA_W   = 512;
    localparam int unsigned PARITY_W = 128;

    typedef struct packed {
        logic [3:0]        line;
        logic [DATA_W-1:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    rs_parity_line_buffer_if bus ();

    rs_parity_line_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PARITY_W-1:0] rep(input logic [7:0] b);
        return {16{b}};
    endfunction

    function automatic logic [DATA_W-1:0] mk(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c, input logic [7:0] d);
        return {rep(a), rep(b), rep(c), rep(d)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic wr(input int addr, input logic [7:0] b);
        bus.wr_val  = 1'b1;
        bus.wr_addr = 6'(addr);
        bus.wr_data = rep(b);
        step();
        bus.wr_val  = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
    endtask

    // Issue one read with the consumer ready; response must appear one cycle after accept.
    task automatic do_read(input logic [3:0] line, output logic [DATA_W-1:0] d);
        int n;
        n = 0;
        bus.rd_resp_rdy = 1'b1;
        bus.rd_req_val  = 1'b1;
        bus.rd_req_addr = line;
        while (!bus.rd_req_rdy && n < 20) begin
            step();
            n++;
        end
        if (n == 20) chk("req_rdy_timeout", '0, DATA_W'(1));
        step();
        bus.rd_req_val = 1'b0;
        chk("resp_latency", DATA_W'(bus.rd_resp_val), DATA_W'(1));
        d = bus.rd_resp_data;
    endtask

    vec_t                 tbl[4];
    logic [DATA_W-1:0]    d;
    logic [DATA_W-1:0]    got[$];
    logic [DATA_W-1:0]    l0, l1, l2;
    logic                 accept_now;
    logic                 saw_val;

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus.clear = 1'b0; bus.wr_val = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_req_val = 1'b0; bus.rd_req_addr = '0; bus.rd_resp_rdy = 1'b1;

        // Reset state
        step(); step();
        chk("rst_req_rdy", DATA_W'(bus.rd_req_rdy), '0);
        chk("rst_resp_val", DATA_W'(bus.rd_resp_val), '0);
        chk("rst_resp_data", bus.rd_resp_data, '0);
        rst = 1'b0;
        step();
        chk("post_rst_req_rdy", DATA_W'(bus.rd_req_rdy), DATA_W'(1));

        // Blocks 0..7 then table of line reads
        for (int i = 0; i < 8; i++) wr(i, 8'(8'h11 * (i + 1)));
        tbl[0] = '{line: 4'd0,  exp: mk(8'h11, 8'h22, 8'h33, 8'h44)};
        tbl[1] = '{line: 4'd1,  exp: mk(8'h55, 8'h66, 8'h77, 8'h88)};
        tbl[2] = '{line: 4'd2,  exp: '0};
        tbl[3] = '{line: 4'd15, exp: '0};
        for (int i = 0; i < 4; i++) begin
            do_read(tbl[i].line, d);
            chk($sformatf("tbl_line%0d", tbl[i].line), d, tbl[i].exp);
        end
        step();

        // Partial line: blocks 0..4 only
        do_clear();
        for (int i = 0; i < 5; i++) wr(i, 8'(8'h11 * (i + 1)));
        do_read(4'd1, d);
        chk("partial_line1", d, mk(8'h55, 8'h00, 8'h00, 8'h00));
        do_read(4'd0, d);
        chk("partial_line0", d, mk(8'h11, 8'h22, 8'h33, 8'h44));
        step();

        // Fill everything, clear with a coincident write, then write block 1
        for (int i = 0; i < 64; i++) wr(i, 8'(i + 1));
        bus.clear = 1'b1;
        wr(5, 8'hDD);
        bus.clear = 1'b0;
        wr(1, 8'hAB);
        do_read(4'd0, d);
        chk("clear_line0", d, mk(8'h00, 8'hAB, 8'h00, 8'h00));
        do_read(4'd1, d);
        chk("clear_wr_same_cycle", d, mk(8'h00, 8'hDD, 8'h00, 8'h00));
        step();

        // Backpressure: three back-to-back requests with the consumer stalled
        wr(8, 8'hEE);
        l0 = mk(8'h00, 8'hAB, 8'h00, 8'h00);
        l1 = mk(8'h00, 8'hDD, 8'h00, 8'h00);
        l2 = mk(8'hEE, 8'h00, 8'h00, 8'h00);
        bus.rd_resp_rdy = 1'b0;
        bus.rd_req_val  = 1'b1;
        bus.rd_req_addr = 4'd0;
        chk("bp_rdy0", DATA_W'(bus.rd_req_rdy), DATA_W'(1));
        step();
        bus.rd_req_addr = 4'd1;
        chk("bp_rdy1", DATA_W'(bus.rd_req_rdy), DATA_W'(1));
        chk("bp_head_first", bus.rd_resp_data, l0);
        step();
        bus.rd_req_addr = 4'd2;
        chk("bp_rdy_full", DATA_W'(bus.rd_req_rdy), '0);
        step();
        chk("bp_hold_val", DATA_W'(bus.rd_resp_val), DATA_W'(1));
        chk("bp_hold_data", bus.rd_resp_data, l0);
        chk("bp_still_full", DATA_W'(bus.rd_req_rdy), '0);
        bus.rd_resp_rdy = 1'b1;
        got.delete();
        for (int c = 0; c < 10; c++) begin
            if (bus.rd_resp_val) got.push_back(bus.rd_resp_data);
            accept_now = bus.rd_req_val && bus.rd_req_rdy;
            step();
            if (accept_now) bus.rd_req_val = 1'b0;
        end
        chk("bp_count", DATA_W'(got.size()), DATA_W'(3));
        if (got.size() == 3) begin
            chk("bp_order0", got[0], l0);
            chk("bp_order1", got[1], l1);
            chk("bp_order2", got[2], l2);
        end

        // Read-first on same-cycle write, re-read sees the new value
        wr(2, 8'h33);
        bus.wr_val = 1'b1; bus.wr_addr = 6'd2; bus.wr_data = rep(8'hCC);
        bus.rd_req_val = 1'b1; bus.rd_req_addr = 4'd0; bus.rd_resp_rdy = 1'b1;
        chk("rf_rdy", DATA_W'(bus.rd_req_rdy), DATA_W'(1));
        step();
        bus.wr_val = 1'b0;
        chk("rf_old", bus.rd_resp_data, mk(8'h00, 8'hAB, 8'h33, 8'h00));
        step();
        bus.rd_req_val = 1'b0;
        chk("rf_new", bus.rd_resp_data, mk(8'h00, 8'hAB, 8'hCC, 8'h00));
        step();

        // Mid-stream reset with the buffer full and a request pending
        bus.rd_resp_rdy = 1'b0;
        bus.rd_req_val  = 1'b1;
        bus.rd_req_addr = 4'd0;
        step(); step();
        chk("mr_full_val", DATA_W'(bus.rd_resp_val), DATA_W'(1));
        rst = 1'b1;
        step();
        chk("mr_val_drop", DATA_W'(bus.rd_resp_val), '0);
        chk("mr_data_zero", bus.rd_resp_data, '0);
        chk("mr_rdy_low", DATA_W'(bus.rd_req_rdy), '0);
        rst = 1'b0;
        bus.rd_req_val  = 1'b0;
        bus.rd_resp_rdy = 1'b1;
        saw_val = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (bus.rd_resp_val) saw_val = 1'b1;
        end
        chk("mr_no_stale", DATA_W'(saw_val), '0);
        chk("mr_rdy_back", DATA_W'(bus.rd_req_rdy), DATA_W'(1));
        do_read(4'd0, d);
        chk("mr_line0_zero", d, '0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
